// File: rtl/scan_capture.sv
// Receiver for the multiplexed digit-scan bus: de-glitches each select dwell,
// rebuilds the 8-digit frame and flags duplicated positions and scan stalls.
module scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  scan_data,
  input  logic [2:0]  scan_sel,
  input  logic        err_clr,
  output logic [31:0] frame,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic        dup_err,
  output logic        stall
);

  localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [2:0]  sel_q,         sel_d;
  logic [3:0]  c_q,           c_d;
  logic [15:0] idle_q,        idle_d;
  logic [31:0] shadow_q,      shadow_d;
  logic [7:0]  seen_q,        seen_d;
  logic [31:0] frame_q,       frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic [7:0]  frame_cnt_q,   frame_cnt_d;
  logic        dup_err_q,     dup_err_d;
  logic        stall_q,       stall_d;

  logic        sel_change;
  logic        capture;
  logic        timed_out;
  logic [7:0]  pos_bit;
  logic [7:0]  seen_base;
  logic [31:0] shadow_upd;

  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    sel_d         = scan_sel;
    c_d           = c_q;
    idle_d        = idle_q;
    shadow_d      = shadow_q;
    seen_d        = seen_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    dup_err_d     = err_clr ? 1'b0 : dup_err_q;
    stall_d       = stall_q;

    sel_change = (scan_sel != sel_q);
    capture    = !sel_change && (c_q == SETTLE_M1);
    timed_out  = (idle_q == TIMEOUT_C);
    pos_bit    = 8'b1 << scan_sel;
    // A timed-out partial frame is dropped before any capture on the same edge.
    seen_base  = timed_out ? 8'h00 : seen_q;
    shadow_upd = shadow_q;
    shadow_upd[{scan_sel, 2'b00} +: 4] = scan_data;

    if (sel_change) begin
      c_d = 4'd1;
    end else if (c_q != SETTLE_C) begin
      c_d = c_q + 4'd1;
    end

    if (timed_out) begin
      stall_d = 1'b1;
      seen_d  = 8'h00;
    end else begin
      idle_d = idle_q + 16'd1;
    end

    if (capture) begin
      shadow_d = shadow_upd;
      idle_d   = 16'd0;
      stall_d  = 1'b0;
      if ((seen_base & pos_bit) != 8'h00) begin
        dup_err_d = 1'b1;
        seen_d    = seen_base;
      end else if ((seen_base | pos_bit) == 8'hFF) begin
        frame_d       = shadow_upd;
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 8'd1;
        seen_d        = 8'h00;
      end else begin
        seen_d = seen_base | pos_bit;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q         <= 3'd0;
      c_q           <= 4'd0;
      idle_q        <= 16'd0;
      // NOTE: the shadow digits are reset too, so a frame assembled right
      // after reset never carries stale or X nibbles.
      shadow_q      <= 32'd0;
      seen_q        <= 8'h00;
      frame_q       <= 32'd0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      dup_err_q     <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      c_q           <= c_d;
      idle_q        <= idle_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      dup_err_q     <= dup_err_d;
      stall_q       <= stall_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign dup_err     = dup_err_q;
  assign stall       = stall_q;

endmodule
